// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling, 3-sample majority voting and a ready/ack handshake
// Ports: clk (rising edge), reset (async, active-low), rx (serial in, idle high, async to clk),
//        rx_ack (clears rx_data_rdy), data_out (last good byte), rx_data_rdy (unread byte level),
//        frame_err / overrun_err (1-clk pulses), busy (receiver not idle)
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int TICK_DIV = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       rx_data_rdy,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic            sync_q, sync_d, rx_s_q, rx_s_d;
    logic [DW-1:0]   div_q, div_d;
    logic [3:0]      tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [1:0]      samp_q, samp_d;
    logic [7:0]      shift_q, shift_d, data_q, data_d;
    logic            armed_q, armed_d, rdy_q, rdy_d, ferr_q, ferr_d, oerr_q, oerr_d, busy_q, busy_d;
    logic            tick, maj, at9, at15;

    always_comb begin
        sync_d     = rx;
        rx_s_d     = sync_q;
        tick       = (div_q == DW'(TICK_DIV - 1));
        div_d      = tick ? '0 : div_q + 1'b1;
        // samples from ticks 7 and 8 are stored; the tick-9 sample is the live rx_s
        maj        = (samp_q[1] & samp_q[0]) | (rx_s_q & (samp_q[1] | samp_q[0]));
        at9        = tick && (tick_cnt_q == 4'd9);
        at15       = tick && (tick_cnt_q == 4'd15);
        state_d    = state_q;
        armed_d    = armed_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        data_d     = data_q;
        rdy_d      = rdy_q & ~rx_ack;
        ferr_d     = 1'b0;
        oerr_d     = 1'b0;
        if (state_q != IDLE && tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd7) samp_d[0] = rx_s_q;
            if (tick_cnt_q == 4'd8) samp_d[1] = rx_s_q;
        end
        case (state_q)
            IDLE: begin
                armed_d = armed_q | rx_s_q;
                if (armed_q && !rx_s_q) begin
                    // the detection cycle is oversample position 0 of start-bit tick 0,
                    // so first-low to data_out is exactly 16*9+10 clk at TICK_DIV=1
                    state_d    = START;
                    div_d      = (TICK_DIV == 1) ? '0 : DW'(1);
                    tick_cnt_d = (TICK_DIV == 1) ? 4'd1 : 4'd0;
                    bit_idx_d  = 3'd0;
                end
            end
            START: begin
                if (at9 && maj) state_d = IDLE;
                else if (at15) state_d = DATA;
            end
            DATA: begin
                if (at9) shift_d = {maj, shift_q[7:1]};
                if (at15) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // decide mid stop bit so a back-to-back start edge is not missed;
                // a bad stop disarms so a held-low break cannot retrigger
                if (at9) begin
                    state_d = IDLE;
                    armed_d = maj;
                    if (maj) begin
                        data_d = shift_q;
                        oerr_d = rdy_q & ~rx_ack;
                        rdy_d  = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            div_q      <= '0;
            tick_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            samp_q     <= 2'd0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            armed_q    <= 1'b0;
            rdy_q      <= 1'b0;
            ferr_q     <= 1'b0;
            oerr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rx_s_q     <= rx_s_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            armed_q    <= armed_d;
            rdy_q      <= rdy_d;
            ferr_q     <= ferr_d;
            oerr_q     <= oerr_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out    = data_q;
    assign rx_data_rdy = rdy_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames against a frame-level receiver model
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] data_out;
    logic       rx_data_rdy, frame_err, overrun_err, busy;

    uart_rx #(.TICK_DIV(1)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_ack(rx_ack),
        .data_out(data_out), .rx_data_rdy(rx_data_rdy),
        .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   ferr_cnt = 0, oerr_cnt = 0, rise_cyc = -1, fall_cyc = 0;
    logic rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun_err) oerr_cnt++;
        if (rx_data_rdy && !rdy_prev) rise_cyc = cyc;
        rdy_prev = rx_data_rdy;
    end

    int         passed = 0, total = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_rdy = 1'b0;
    int         exp_ferr = 0, exp_oerr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_data"}, data_out, exp_data);
        check({tag, "_rdy"}, rx_data_rdy, exp_rdy);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_oerr"}, oerr_cnt, exp_oerr);
    endtask

    // frame-level reference: a good stop bit delivers the byte, overrun if an unread byte
    // was pending and not acknowledged in the same cycle; a bad stop bit only flags
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack_same);
        if (stop) begin
            if (exp_rdy && !ack_same) exp_oerr++;
            exp_data = b;
            exp_rdy  = 1'b1;
        end else begin
            exp_ferr++;
        end
    endtask

    // line is left at the stop-bit level afterwards
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        fall_cyc = cyc;
        rx = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (16) @(posedge clk);
        end
        #1 rx = stop;
        repeat (16) @(posedge clk);
    endtask

    task automatic do_ack();
        @(posedge clk); #1 rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
        exp_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        logic       st;
        #5 reset = 1'b0;
        idle(3);
        check("rst_data", data_out, 8'h00);
        check("rst_rdy", rx_data_rdy, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_oerr", overrun_err, 1'b0);
        reset = 1'b1;
        idle(5);

        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b1, 1'b0);
        #1 check_state("good55");
        // 2 sync clk plus 154 clk from rx_s low to the data_out update
        check("latency", rise_cyc - fall_cyc, 156);
        check("busy_after55", busy, 1'b0);
        do_ack();
        check("ack55_rdy", rx_data_rdy, 1'b0);

        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("glitch_busy_hi", busy, 1'b1);
        rx = 1'b1;
        idle(20);
        check("glitch_busy_lo", busy, 1'b0);
        check_state("glitch");
        send_frame(8'hA3, 1'b1);
        model_frame(8'hA3, 1'b1, 1'b0);
        #1 check_state("a3");
        do_ack();

        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        idle(200);
        check_state("ferr3c");
        check("break_busy", busy, 1'b0);
        rx = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1, 1'b0);
        #1 check_state("after_break81");
        do_ack();

        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        #1 check_state("ovr11");
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1, 1'b0);
        #1 check_state("ovr22");

        fork
            send_frame(8'h7E, 1'b1);
            begin
                repeat (156) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        model_frame(8'h7E, 1'b1, 1'b1);
        #1 check_state("collide7e");
        do_ack();

        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (89) @(posedge clk);
                #1 check("midframe_busy", busy, 1'b1);
                reset = 1'b0;
                #1;
                check("midrst_data", data_out, 8'h00);
                check("midrst_rdy", rx_data_rdy, 1'b0);
                check("midrst_busy", busy, 1'b0);
                repeat (10) @(posedge clk);
                #1 reset = 1'b1;
            end
        join
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        idle(20);
        check_state("post_rst");
        check("post_rst_busy", busy, 1'b0);
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1, 1'b0);
        #1 check_state("clean5a");
        do_ack();

        for (int i = 0; i < 10; i++) begin
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) != 0);
            send_frame(b, st);
            model_frame(b, st, 1'b0);
            #1 check_state("rand");
            if (!st) begin
                rx = 1'b1;
                idle(3);
            end
            if ($urandom_range(0, 1) == 1) do_ack();
            idle($urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive half of the lab UART: recovers 8N1 frames from the `rx` line and presents each byte with a ready/acknowledge handshake.
- Pairs with the existing transmitter, so the bench can loop `tx` back into this block.
- Uses 16x oversampling with 3-sample majority voting, rejects glitched start bits, and flags framing and overrun errors.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- TICK_DIV, CLK_FREQ/(BAUD*16): clocks per oversample tick.
  - Integer division, truncated; default resolves to 325.
  - Must be >= 1; override directly in simulation.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx  in  1  serial input; idle high; asynchronous to clk.
- rx_ack  in  1  consumer acknowledge; clears rx_data_rdy.
- data_out  out  8  last good received byte, LSB first on the line.
- rx_data_rdy  out  1  level: unread byte valid in data_out.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun_err  out  1  one-cycle pulse: good byte completed while rx_data_rdy was already 1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (reset = 0):
  - data_out = 0x00; rx_data_rdy, frame_err, overrun_err, busy = 0.
  - FSM = IDLE, disarmed; all counters = 0.
  - The synchronizer flops reset to 1.
- Input sync: rx passes through 2 flops to give rx_s. All decisions use rx_s, so the line-to-logic latency is 2 clk.
- Tick generator:
  - Counts 0..TICK_DIV-1 and asserts a 1-clk tick on the terminal count.
  - Free-running, but restarts at 0 on the start-edge detection.
- Bit timing:
  - A 4-bit tick counter runs 0..15 inside each bit.
  - rx_s is sampled on ticks 7, 8 and 9; the bit value is the majority of those 3 samples.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: arms only after rx_s = 1 has been seen. When armed, rx_s = 0 goes to START with the tick and bit counters cleared. busy rises the cycle after the edge is detected.
  - START:
    - Majority at tick 9 = 1: glitch; return to IDLE (still armed) with no outputs touched.
    - Majority = 0: stay until tick 15, then go to DATA with bit index 0.
  - DATA: the majority value of each bit is shifted into a shift register LSB-first. After tick 15 of bit index 7, go to STOP.
  - STOP: the decision is made at tick 9 of the stop bit, not at its end, so the receiver resyncs on back-to-back frames.
    - Majority = 1 (good frame):
      - data_out <= shift register.
      - If rx_data_rdy was already 1, overrun_err pulses for 1 clk.
      - rx_data_rdy <= 1.
      - Go to IDLE, armed.
    - Majority = 0: frame_err pulses for 1 clk; data_out and rx_data_rdy are unchanged. Go to IDLE disarmed, which waits for rx_s = 1 so a break does not retrigger.
- Handshake:
  - rx_ack = 1 while rx_data_rdy = 1 clears rx_data_rdy on the next edge.
  - rx_ack while rx_data_rdy = 0 is ignored.
  - If rx_ack and a good-frame completion occur in the same cycle, the completion wins: rx_data_rdy stays 1, data_out takes the new byte, and no overrun is flagged.
- Reset mid-frame: everything returns immediately to reset values. Reception resumes only after rx_s = 1 has been seen, then a falling edge.
- Frame length: with TICK_DIV = 1, from the first rx_s low to the data_out update is 16*9 + 10 = 154 clk.

Test Plan:
- Config for all tests: TICK_DIV = 1 (16 clk per bit, 20 ns clk); the bench drives rx.
- Good frame: drive 0x55 in 8N1 -> rx_data_rdy rises at 154 clk after rx_s falls, data_out = 0x55, frame_err = 0. Pulse rx_ack -> rx_data_rdy = 0 next cycle.
- Glitch: rx low for 4 clk, then high -> block returns to IDLE, busy drops, no output change. A following 0xA3 frame is received correctly.
- Framing error: 0x3C sent with stop bit = 0 -> frame_err pulses 1 clk, rx_data_rdy stays 0, data_out unchanged. rx is held low 200 clk after the frame, then 0x81 is sent -> 0x81 received and no spurious frame during the low period.
- Overrun: send 0x11 (not acked), then 0x22 -> on the second frame overrun_err pulses, data_out = 0x22, rx_data_rdy = 1.
- Ack collision: assert rx_ack exactly on the completion cycle of 0x7E while a previous byte is pending -> rx_data_rdy stays 1, data_out = 0x7E, overrun_err = 0.
- Reset mid-frame: assert reset low during data bit 4 of 0xF0 -> all outputs 0 immediately. After release, a clean 0x5A frame is received correctly.
